multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 Write-enable outputs SHALL be memwrite, irwrite, regwrite, pcwrite, branch and pcen, each 1-bit.
REQ-007 Datapath selects SHALL be: iord 1, regdst 1, memtoreg 1, alusrca 1, alusrcb 2, aluop 2, pcsrc 2.
REQ-008 state  output  4  current state encoding, for debug and the bench.

Function
REQ-009 The block SHALL be a Moore FSM; every output except pcen SHALL decode from the state register alone.
REQ-010 pcen SHALL equal pcwrite OR (branch AND zero), combinationally.
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP.
REQ-012 Opcodes SHALL be: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw or sw; ->EXECUTE for R-type; ->BRANCH for beq; ->ADDIEXEC for addi; ->JUMP for j.
- MEMADR->MEMRD for lw, ->MEMWR for sw.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all ->FETCH.
REQ-014 An unrecognised opcode in DECODE SHALL return the FSM to FETCH with no register or memory write; op is sampled only in DECODE and MEMADR.
REQ-015 alusrcb encoding SHALL be: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
REQ-016 Outputs not listed for a state SHALL be 0.
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEXEC: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-017 Instruction latency in cycles, FETCH inclusive, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-018 Each write enable SHALL be high for exactly one cycle per instruction, in its state only.
REQ-019 A change of zero outside BRANCH SHALL have no effect on pcen.

Reset
REQ-020 Asserting reset SHALL force the state to FETCH immediately, without waiting for a clock edge, including mid-instruction.
REQ-021 While reset is high, memwrite, irwrite, regwrite, pcwrite, branch and pcen SHALL be 0; selects SHALL show the FETCH values.
REQ-022 The first rising edge after reset deasserts SHALL occur in FETCH with irwrite=1 and pcwrite=1.

Structure
REQ-023 State encodings, opcode constants and alusrcb/pcsrc/aluop encodings SHALL live in the shared MIPS package.
REQ-024 The block SHALL be a single module with no sub-modules; the next-state and output decoders are separate combinational processes.

Verification
REQ-025 lw (op=100011) after reset -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, then FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-026 beq with zero=1 -> pcen=1 in cycle 3 with pcsrc=01; repeating with zero=0 -> pcen=0 in cycle 3.
REQ-027 sw, then R-type, then j back-to-back -> memwrite in cycle 4, regwrite with regdst=1 in cycle 8, pcwrite with pcsrc=10 in cycle 11.
REQ-028 op=111111 in DECODE -> next state FETCH; no write enable asserted for that instruction.
REQ-029 reset pulsed asynchronously during MEMRD -> state=FETCH before the next edge, all write enables 0 while reset is high, and a normal fetch follows.
REQ-030 alusrcb checked per state for lw/addi/beq -> 01 in FETCH, 11 in DECODE, 10 in MEMADR/ADDIEXEC, 00 in BRANCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the multicycle controller.
// Holds the state encodings, opcodes and datapath select encodings.
package mips_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_EXECUTE  = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEXEC = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle MIPS datapath (lw/sw/R/beq/addi/j).
// Write enables are forced low while reset is held so a held reset never writes.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    logic       memwrite_s, irwrite_s, regwrite_s, pcwrite_s, branch_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                alusrcb   = SRCB_FOUR;
                irwrite_s = 1'b1;
                pcwrite_s = 1'b1;
            end
            S_DECODE: alusrcb = SRCB_IMMSH2;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch_s = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc     = PCSRC_JUMP;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is asynchronous, so gate the enables combinationally as well.
    assign memwrite = memwrite_s & ~reset;
    assign irwrite  = irwrite_s  & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcwrite  = pcwrite_s  & ~reset;
    assign branch   = branch_s   & ~reset;
    assign pcen     = pcwrite | (branch & zero);
    assign state    = state_q;

endmodule
